// File: rtl/cpu_io_run_ctrl.sv
// cpu_io_run_ctrl: run/halt control plus the CPU's input and output ports.
// The input port is a single latched register with valid and sticky overrun flags.
// The output port is a small FIFO, so "out" instructions do not stall while there is space.
// A halt instruction can optionally wait in DRAIN until the output FIFO has emptied.
module cpu_io_run_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int OUT_DEPTH     = 4,
    parameter int AUTO_START    = 1,
    parameter int DRAIN_ON_HALT = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic                           halt_req_i,
    output logic                           run_o,
    input  logic                           in_strobe_i,
    input  logic [DATA_WIDTH-1:0]          in_data_i,
    input  logic                           in_read_i,
    output logic [DATA_WIDTH-1:0]          in_port_out_o,
    output logic                           in_valid_o,
    output logic                           in_overrun_o,
    input  logic                           out_write_i,
    input  logic [DATA_WIDTH-1:0]          out_data_cpu_i,
    output logic                           out_full_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [$clog2(OUT_DEPTH+1)-1:0] out_count_o
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic                  first_q;

    logic [DATA_WIDTH-1:0] in_data_q;
    logic                  in_valid_q;
    logic                  in_overrun_q;

    logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // FIFO handshake decode; a pop at full frees the slot for a same-cycle write
    always_comb begin
        fifo_full  = (count_q == CW'(OUT_DEPTH));
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && out_ready_i;
        push       = out_write_i && (!fifo_full || pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= out_data_cpu_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Input latch: a strobe always captures data; overrun flags unread data being overwritten
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_data_q    <= '0;
            in_valid_q   <= 1'b0;
            in_overrun_q <= 1'b0;
        end else begin
            if (in_strobe_i) begin
                in_data_q  <= in_data_i;
                in_valid_q <= 1'b1;
                if (in_valid_q && !in_read_i) begin
                    in_overrun_q <= 1'b1;
                end
            end else if (in_read_i) begin
                in_valid_q <= 1'b0;
            end
        end
    end

    // Run FSM state register; first_q marks the first edge after reset for auto-start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
        end
    end

    // Run FSM next state with priority Stop > Halt_Req > Start
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!stop_i && ((first_q && (AUTO_START != 0)) || start_i)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = HALTED;
                end else if (halt_req_i) begin
                    if ((DRAIN_ON_HALT != 0) && !fifo_empty) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = HALTED;
                    end
                end
            end
            DRAIN: begin
                if (stop_i || (count_d == '0)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (start_i && !stop_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: Run comes straight from the state register, the ports from their storage
    always_comb begin
        run_o         = (state_q == RUN);
        in_port_out_o = in_data_q;
        in_valid_o    = in_valid_q;
        in_overrun_o  = in_overrun_q;
        out_full_o    = fifo_full;
        out_valid_o   = !fifo_empty;
        out_data_o    = mem_q[rd_ptr_q];
        out_count_o   = count_q;
    end

endmodule

// File: tb/tb_cpu_io_run_ctrl.sv
// tb_cpu_io_run_ctrl: directed and random stimulus checked against a queue-based model.
module tb_cpu_io_run_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_DRAIN  = 2;
    localparam int S_HALTED = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          haltReq = 1'b0;
    logic          run;
    logic          inStrobe = 1'b0;
    logic [DW-1:0] inData = '0;
    logic          inRead = 1'b0;
    logic [DW-1:0] inPortOut;
    logic          inValid;
    logic          inOverrun;
    logic          outWrite = 1'b0;
    logic [DW-1:0] outDataCpu = '0;
    logic          outFull;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [CW-1:0] outCount;

    int errors = 0;
    int checks = 0;

    int            mState;
    bit            mFirst;
    bit            mFresh;
    logic [DW-1:0] mInData;
    bit            mInValid;
    bit            mOverrun;
    logic [DW-1:0] mQ[$];

    cpu_io_run_ctrl #(
        .DATA_WIDTH(DW),
        .OUT_DEPTH(DEPTH),
        .AUTO_START(1),
        .DRAIN_ON_HALT(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .stop_i(stop),
        .halt_req_i(haltReq),
        .run_o(run),
        .in_strobe_i(inStrobe),
        .in_data_i(inData),
        .in_read_i(inRead),
        .in_port_out_o(inPortOut),
        .in_valid_o(inValid),
        .in_overrun_o(inOverrun),
        .out_write_i(outWrite),
        .out_data_cpu_i(outDataCpu),
        .out_full_o(outFull),
        .out_data_o(outData),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_count_o(outCount)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState   = S_IDLE;
        mFirst   = 1'b1;
        mFresh   = 1'b1;
        mInData  = '0;
        mInValid = 1'b0;
        mOverrun = 1'b0;
        mQ.delete();
    endtask

    // One clock edge of the reference model, using the inputs that were present at the edge
    task automatic modelStep();
        int  oldSize;
        bit  doPop;
        bit  doPush;
        oldSize = mQ.size();
        doPop   = (oldSize > 0) && outReady;
        doPush  = outWrite && ((oldSize < DEPTH) || doPop);
        if (doPop) void'(mQ.pop_front());
        if (doPush) begin
            mQ.push_back(outDataCpu);
            mFresh = 1'b0;
        end
        if (inStrobe) begin
            if (mInValid && !inRead) mOverrun = 1'b1;
            mInData  = inData;
            mInValid = 1'b1;
        end else if (inRead) begin
            mInValid = 1'b0;
        end
        case (mState)
            S_IDLE:   if (!stop && (mFirst || start)) mState = S_RUN;
            S_RUN:    if (stop) mState = S_HALTED;
                      else if (haltReq) mState = (oldSize > 0) ? S_DRAIN : S_HALTED;
            S_DRAIN:  if (stop || mQ.size() == 0) mState = S_HALTED;
            default:  if (start && !stop) mState = S_RUN;
        endcase
        mFirst = 1'b0;
    endtask

    task automatic checkAll();
        checkOutput("run", run, (mState == S_RUN));
        checkOutput("inPortOut", inPortOut, mInData);
        checkOutput("inValid", inValid, mInValid);
        checkOutput("inOverrun", inOverrun, mOverrun);
        checkOutput("outValid", outValid, (mQ.size() > 0));
        checkOutput("outCount", outCount, mQ.size());
        checkOutput("outFull", outFull, (mQ.size() == DEPTH));
        if (mQ.size() > 0) checkOutput("outData", outData, mQ[0]);
        else if (mFresh) checkOutput("outDataReset", outData, 0);
    endtask

    task automatic applyStimulus(input bit st, input bit sp, input bit hr, input bit sb,
                                 input logic [DW-1:0] d, input bit rd, input bit wr,
                                 input logic [DW-1:0] wd, input bit rdy);
        start      = st;
        stop       = sp;
        haltReq    = hr;
        inStrobe   = sb;
        inData     = d;
        inRead     = rd;
        outWrite   = wr;
        outDataCpu = wd;
        outReady   = rdy;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic idleCycle(input bit rdy);
        applyStimulus(0, 0, 0, 0, '0, 0, 0, '0, rdy);
    endtask

    task automatic writeOut(input logic [DW-1:0] wd, input bit rdy);
        applyStimulus(0, 0, 0, 0, '0, 0, 1, wd, rdy);
    endtask

    initial begin
        // Power-up with reset held for three edges
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll();
        rst = 1'b0;
        idleCycle(0);

        // Input latch, overwrite and overrun behaviour
        applyStimulus(0, 0, 0, 1, 32'h0000_00A5, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_0011, 1, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 1, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 1, 0, '0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_00A5, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_005A, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_0077, 1, 0, '0, 0);

        // FIFO fill, dropped write at full, ordered drain, pointer wrap
        for (int i = 1; i <= 5; i++) writeOut(DW'(i), 0);
        for (int i = 0; i < 4; i++) idleCycle(1);
        for (int i = 6; i <= 8; i++) writeOut(DW'(i), 0);
        for (int i = 0; i < 3; i++) idleCycle(1);

        // Push and pop together while full
        for (int i = 10; i <= 13; i++) writeOut(DW'(i), 0);
        writeOut(DW'(9), 1);
        for (int i = 0; i < 4; i++) idleCycle(1);

        // Drain on halt; Start is ignored while draining
        writeOut(DW'(21), 0);
        writeOut(DW'(22), 0);
        applyStimulus(0, 0, 1, 0, '0, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, 0, '0, 0, 0, '0, 1);
        idleCycle(1);
        applyStimulus(1, 0, 0, 0, '0, 0, 0, '0, 0);

        // Stop beats Halt_Req and Start
        writeOut(DW'(31), 0);
        applyStimulus(0, 1, 1, 0, '0, 0, 0, '0, 0);
        applyStimulus(1, 1, 0, 0, '0, 0, 0, '0, 1);
        applyStimulus(1, 0, 0, 0, '0, 0, 0, '0, 0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, $urandom,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom,
                          $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 6; i++) idleCycle(1);
        applyStimulus(1, 0, 0, 0, '0, 0, 0, '0, 1);
        for (int i = 41; i <= 43; i++) writeOut(DW'(i), 0);
        applyStimulus(0, 0, 1, 0, '0, 0, 0, '0, 0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        rst = 1'b0;
        idleCycle(0);
        writeOut(DW'(51), 0);
        idleCycle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
